// File: rtl/pwm_avalon_ramp_master_if.sv
// Avalon-MM bus between the ramp master and one PWM agent s0 port.
interface pwm_avalon_ramp_master_if;
    logic [1:0]  avm_m0_address;
    logic        avm_m0_read;
    logic        avm_m0_write;
    logic [31:0] avm_m0_writedata;
    logic [3:0]  avm_m0_byteenable;
    logic [31:0] avm_m0_readdata;
    logic        avm_m0_waitrequest;

    modport master (
        output avm_m0_address, avm_m0_read, avm_m0_write, avm_m0_writedata, avm_m0_byteenable,
        input  avm_m0_readdata, avm_m0_waitrequest
    );

    modport slave (
        input  avm_m0_address, avm_m0_read, avm_m0_write, avm_m0_writedata, avm_m0_byteenable,
        output avm_m0_readdata, avm_m0_waitrequest
    );
endinterface

// File: rtl/pwm_avalon_ramp_master.sv
// Avalon-MM master: programs a PWM agent, then ramps pulse_width between 0 and PERIOD.
// Commands appear the cycle after state entry and hold under waitrequest, bounded by TIMEOUT.
module pwm_avalon_ramp_master #(
    parameter logic [31:0] PERIOD      = 32'd500000,
    parameter logic [31:0] STEP        = 32'd5000,
    parameter logic [31:0] STEP_CYCLES = 32'd50000,
    parameter logic [31:0] TIMEOUT     = 32'd1024
) (
    input  logic                            csi_clk,
    input  logic                            rsi_rst_n,
    pwm_avalon_ramp_master_if.master        avm,
    input  logic                            coe_start,
    input  logic                            coe_stop,
    output logic                            coe_busy,
    output logic                            coe_error,
    output logic [31:0]                     coe_width
);

    typedef enum logic [3:0] {
        S_IDLE, S_WR_PERIOD, S_WR_WIDTH0, S_WR_ENABLE, S_RD_ENABLE,
        S_WAIT, S_WR_WIDTH, S_WR_DISABLE, S_ERROR
    } state_t;

    state_t      r_state;
    logic [1:0]  r_addr;
    logic        r_rd;
    logic        r_wr;
    logic [31:0] r_wdata;
    logic [3:0]  r_be;
    logic        r_error;
    logic [31:0] r_width_out;
    logic [31:0] r_width;
    logic        r_dir_down;
    logic        r_stop;
    logic [31:0] r_cnt;
    logic [31:0] r_to;

    logic        w_busy;
    logic [32:0] w_sum;
    logic [31:0] w_next;
    logic        w_next_down;

    assign w_busy = (r_state != S_IDLE) && (r_state != S_ERROR);
    assign w_sum  = {1'b0, r_width} + {1'b0, STEP};

    // Saturate at both ends and reverse direction there, so the ramp never wraps.
    always_comb begin
        w_next      = r_width;
        w_next_down = r_dir_down;
        if (!r_dir_down) begin
            if (w_sum >= {1'b0, PERIOD}) begin
                w_next      = PERIOD;
                w_next_down = 1'b1;
            end else begin
                w_next = w_sum[31:0];
            end
        end else begin
            if (r_width <= STEP) begin
                w_next      = '0;
                w_next_down = 1'b0;
            end else begin
                w_next = r_width - STEP;
            end
        end
    end

    always_ff @(posedge csi_clk) begin
        if (!rsi_rst_n) begin
            r_state     <= S_IDLE;
            r_addr      <= '0;
            r_rd        <= 1'b0;
            r_wr        <= 1'b0;
            r_wdata     <= '0;
            r_be        <= '0;
            r_error     <= 1'b0;
            r_width_out <= '0;
            r_width     <= '0;
            r_dir_down  <= 1'b0;
            r_stop      <= 1'b0;
            r_cnt       <= '0;
            r_to        <= '0;
        end else begin
            if (w_busy && coe_stop) begin
                r_stop <= 1'b1;
            end
            case (r_state)
                S_IDLE, S_ERROR: begin
                    if (coe_start) begin
                        r_state    <= S_WR_PERIOD;
                        r_error    <= 1'b0;
                        r_width    <= '0;
                        r_dir_down <= 1'b0;
                        r_stop     <= 1'b0;
                        r_to       <= '0;
                        r_wr       <= 1'b1;
                        r_be       <= 4'b1111;
                        r_addr     <= 2'd1;
                        r_wdata    <= PERIOD;
                    end
                end
                S_WAIT: begin
                    if (r_cnt <= 32'd1) begin
                        r_wr <= 1'b1;
                        r_be <= 4'b1111;
                        if (r_stop) begin
                            r_state <= S_WR_DISABLE;
                            r_addr  <= 2'd2;
                            r_wdata <= '0;
                        end else begin
                            r_state    <= S_WR_WIDTH;
                            r_addr     <= 2'd0;
                            r_wdata    <= w_next;
                            r_width    <= w_next;
                            r_dir_down <= w_next_down;
                        end
                    end else begin
                        r_cnt <= r_cnt - 32'd1;
                    end
                end
                default: begin
                    if (avm.avm_m0_waitrequest) begin
                        // Stall budget exhausted: drop the command and park in ERROR.
                        if (r_to >= TIMEOUT - 32'd1) begin
                            r_state <= S_ERROR;
                            r_error <= 1'b1;
                            r_rd    <= 1'b0;
                            r_wr    <= 1'b0;
                            r_be    <= '0;
                            r_addr  <= '0;
                            r_wdata <= '0;
                            r_to    <= '0;
                        end else begin
                            r_to <= r_to + 32'd1;
                        end
                    end else begin
                        r_to <= '0;
                        case (r_state)
                            S_WR_PERIOD: begin
                                r_state <= S_WR_WIDTH0;
                                r_addr  <= 2'd0;
                                r_wdata <= '0;
                            end
                            S_WR_WIDTH0: begin
                                r_state <= S_WR_ENABLE;
                                r_addr  <= 2'd2;
                                r_wdata <= 32'd1;
                            end
                            S_WR_ENABLE: begin
                                r_state <= S_RD_ENABLE;
                                r_wr    <= 1'b0;
                                r_rd    <= 1'b1;
                                r_addr  <= 2'd2;
                                r_wdata <= '0;
                            end
                            S_RD_ENABLE: begin
                                r_rd   <= 1'b0;
                                r_be   <= '0;
                                r_addr <= '0;
                                if (avm.avm_m0_readdata[0]) begin
                                    r_state <= S_WAIT;
                                    r_cnt   <= STEP_CYCLES;
                                end else begin
                                    r_state <= S_ERROR;
                                    r_error <= 1'b1;
                                end
                            end
                            S_WR_WIDTH: begin
                                r_state     <= S_WAIT;
                                r_cnt       <= STEP_CYCLES;
                                r_width_out <= r_wdata;
                                r_wr        <= 1'b0;
                                r_be        <= '0;
                                r_addr      <= '0;
                                r_wdata     <= '0;
                            end
                            default: begin
                                r_state <= S_IDLE;
                                r_rd    <= 1'b0;
                                r_wr    <= 1'b0;
                                r_be    <= '0;
                                r_addr  <= '0;
                                r_wdata <= '0;
                            end
                        endcase
                    end
                end
            endcase
        end
    end

    assign avm.avm_m0_address    = r_addr;
    assign avm.avm_m0_read       = r_rd;
    assign avm.avm_m0_write      = r_wr;
    assign avm.avm_m0_writedata  = r_wdata;
    assign avm.avm_m0_byteenable = r_be;
    assign coe_busy              = w_busy;
    assign coe_error             = r_error;
    assign coe_width             = r_width_out;

endmodule

// File: tb/tb_pwm_avalon_ramp_master.sv
// Directed bench: PWM agent model with configurable stalls, vector table for the ramp, hand sequences for corners.
module tb_pwm_avalon_ramp_master;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic stop = 1'b0;
    logic busy, error;
    logic [31:0] width;

    always #5 clk = ~clk;

    pwm_avalon_ramp_master_if bus ();

    pwm_avalon_ramp_master #(
        .PERIOD(32'd100), .STEP(32'd30), .STEP_CYCLES(32'd4), .TIMEOUT(32'd8)
    ) dut (
        .csi_clk(clk), .rsi_rst_n(rst_n), .avm(bus),
        .coe_start(start), .coe_stop(stop),
        .coe_busy(busy), .coe_error(error), .coe_width(width)
    );

    typedef struct {
        bit          wr;
        logic [1:0]  addr;
        logic [31:0] data;
        int          cyc;
    } txn_t;

    typedef struct {
        bit          wr;
        logic [1:0]  addr;
        logic [31:0] data;
        int          gap;
    } vec_t;

    // Agent model
    int          stall_cfg = 0;
    bit          stuck = 1'b0;
    bit          force_en0 = 1'b0;
    int          stall_cnt = 0;
    int          cyc = 0;
    int          n_unstable = 0;
    logic [31:0] regs [4];
    logic [1:0]  cap_a;
    logic        cap_r, cap_w;
    logic [31:0] cap_d;
    txn_t        log_q [$];

    assign bus.avm_m0_waitrequest = stuck ||
        ((bus.avm_m0_read || bus.avm_m0_write) && (stall_cnt < stall_cfg));
    assign bus.avm_m0_readdata = force_en0 ? 32'd0 : regs[bus.avm_m0_address];

    always @(posedge clk) begin
        txn_t t;
        logic changed;
        cyc <= cyc + 1;
        changed = (bus.avm_m0_address != cap_a) || (bus.avm_m0_read != cap_r) ||
                  (bus.avm_m0_write != cap_w) || (bus.avm_m0_writedata != cap_d);
        if (!rst_n) begin
            stall_cnt <= 0;
        end else if (bus.avm_m0_read || bus.avm_m0_write) begin
            if (bus.avm_m0_byteenable != 4'b1111) n_unstable <= n_unstable + 1;
            if (bus.avm_m0_waitrequest) begin
                if (stall_cnt == 0) begin
                    cap_a <= bus.avm_m0_address;
                    cap_r <= bus.avm_m0_read;
                    cap_w <= bus.avm_m0_write;
                    cap_d <= bus.avm_m0_writedata;
                end else if (changed) begin
                    n_unstable <= n_unstable + 1;
                end
                stall_cnt <= stall_cnt + 1;
            end else begin
                if (stall_cnt != 0 && changed) n_unstable <= n_unstable + 1;
                t.wr   = bus.avm_m0_write;
                t.addr = bus.avm_m0_address;
                t.data = bus.avm_m0_write ? bus.avm_m0_writedata : bus.avm_m0_readdata;
                t.cyc  = cyc;
                log_q.push_back(t);
                if (bus.avm_m0_write) regs[bus.avm_m0_address] <= bus.avm_m0_writedata;
                stall_cnt <= 0;
            end
        end
    end

    int n_tests = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic expire(input string nm);
        n_tests++;
        n_fail++;
        $display("FAIL %s: wait budget expired", nm);
    endtask

    task automatic pulse_start(output int s);
        start = 1'b1;
        s = cyc;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_log(input int n, input int budget, input string nm);
        int b = budget;
        while (log_q.size() < n && b > 0) begin
            @(negedge clk);
            b--;
        end
        if (log_q.size() < n) expire(nm);
    endtask

    task automatic wait_idle(input int budget, input string nm);
        int b = budget;
        while (busy && b > 0) begin
            @(negedge clk);
            b--;
        end
        if (busy) expire(nm);
    endtask

    task automatic wait_stall(input int budget, input string nm);
        int b = budget;
        while (!(bus.avm_m0_write && bus.avm_m0_waitrequest) && b > 0) begin
            @(negedge clk);
            b--;
        end
        if (!(bus.avm_m0_write && bus.avm_m0_waitrequest)) expire(nm);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_write"}, {31'd0, bus.avm_m0_write}, 32'd0);
        chk({tag, "_read"},  {31'd0, bus.avm_m0_read}, 32'd0);
        chk({tag, "_be"},    {28'd0, bus.avm_m0_byteenable}, 32'd0);
        chk({tag, "_addr"},  {30'd0, bus.avm_m0_address}, 32'd0);
        chk({tag, "_wdata"}, bus.avm_m0_writedata, 32'd0);
        chk({tag, "_busy"},  {31'd0, busy}, 32'd0);
        chk({tag, "_error"}, {31'd0, error}, 32'd0);
        chk({tag, "_width"}, width, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs [13];
        int s, prev;
        vecs[0]  = '{1'b1, 2'd1, 32'd100, 1};
        vecs[1]  = '{1'b1, 2'd0, 32'd0,   1};
        vecs[2]  = '{1'b1, 2'd2, 32'd1,   1};
        vecs[3]  = '{1'b0, 2'd2, 32'd1,   1};
        vecs[4]  = '{1'b1, 2'd0, 32'd30,  5};
        vecs[5]  = '{1'b1, 2'd0, 32'd60,  5};
        vecs[6]  = '{1'b1, 2'd0, 32'd90,  5};
        vecs[7]  = '{1'b1, 2'd0, 32'd100, 5};
        vecs[8]  = '{1'b1, 2'd0, 32'd70,  5};
        vecs[9]  = '{1'b1, 2'd0, 32'd40,  5};
        vecs[10] = '{1'b1, 2'd0, 32'd10,  5};
        vecs[11] = '{1'b1, 2'd0, 32'd0,   5};
        vecs[12] = '{1'b1, 2'd0, 32'd30,  5};

        repeat (3) @(negedge clk);
        chk_all_zero("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // Ramp with zero-wait agent, table driven
        pulse_start(s);
        wait_log(13, 200, "ramp_log");
        if (log_q.size() >= 13) begin
            prev = s;
            for (int i = 0; i < 13; i++) begin
                chk($sformatf("ramp%0d_wr", i),   {31'd0, log_q[i].wr}, {31'd0, vecs[i].wr});
                chk($sformatf("ramp%0d_addr", i), {30'd0, log_q[i].addr}, {30'd0, vecs[i].addr});
                chk($sformatf("ramp%0d_data", i), log_q[i].data, vecs[i].data);
                chk($sformatf("ramp%0d_gap", i),  log_q[i].cyc - prev, vecs[i].gap);
                prev = log_q[i].cyc;
            end
        end
        chk("ramp_width", width, 32'd30);
        chk("ramp_busy", {31'd0, busy}, 32'd1);

        // Stop pulsed during a stalled WR_WIDTH
        stall_cfg = 3;
        log_q.delete();
        wait_stall(50, "stop_stall");
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        wait_idle(100, "stop_idle");
        chk("stop_count", log_q.size(), 32'd2);
        if (log_q.size() >= 2) begin
            chk("stop_w_addr", {30'd0, log_q[0].addr}, 32'd0);
            chk("stop_w_data", log_q[0].data, 32'd60);
            chk("stop_d_addr", {30'd0, log_q[1].addr}, 32'd2);
            chk("stop_d_data", log_q[1].data, 32'd0);
            chk("stop_d_gap", log_q[1].cyc - log_q[0].cyc, 32'd8);
        end
        chk("stop_width", width, 32'd60);
        chk("stop_error", {31'd0, error}, 32'd0);

        // Stalled init: each access completes once, 4 cycles apart
        log_q.delete();
        pulse_start(s);
        wait_log(5, 200, "stall_log");
        if (log_q.size() >= 5) begin
            prev = s;
            for (int i = 0; i < 4; i++) begin
                chk($sformatf("stall%0d_addr", i), {30'd0, log_q[i].addr}, {30'd0, vecs[i].addr});
                chk($sformatf("stall%0d_data", i), log_q[i].data, vecs[i].data);
                chk($sformatf("stall%0d_gap", i), log_q[i].cyc - prev, 32'd4);
                prev = log_q[i].cyc;
            end
            chk("stall_first_width", log_q[4].data, 32'd30);
            chk("stall_first_gap", log_q[4].cyc - log_q[3].cyc, 32'd8);
            chk("stall_count", log_q.size(), 32'd5);
        end
        chk("stall_stable", n_unstable, 32'd0);

        // Reset in the middle of a stalled write
        wait_stall(50, "rst_stall");
        rst_n = 1'b0;
        @(negedge clk);
        chk_all_zero("midrst");
        rst_n = 1'b1;
        stall_cfg = 0;
        @(negedge clk);
        log_q.delete();
        pulse_start(s);
        wait_log(5, 100, "restart_log");
        if (log_q.size() >= 5) begin
            chk("restart_data", log_q[4].data, 32'd30);
            chk("restart_gap", log_q[4].cyc - s, 32'd9);
        end
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        wait_idle(100, "restart_idle");
        if (log_q.size() >= 6) begin
            chk("restart_dis_addr", {30'd0, log_q[5].addr}, 32'd2);
            chk("restart_dis_data", log_q[5].data, 32'd0);
        end else begin
            expire("restart_dis_log");
        end
        chk("restart_width", width, 32'd30);

        // Enable readback 0 -> ERROR, then restart from ERROR
        force_en0 = 1'b1;
        log_q.delete();
        pulse_start(s);
        begin
            int b = 50;
            while (!error && b > 0) begin @(negedge clk); b--; end
            if (!error) expire("err_wait");
        end
        chk("err_flag", {31'd0, error}, 32'd1);
        chk("err_busy", {31'd0, busy}, 32'd0);
        chk("err_count", log_q.size(), 32'd4);
        if (log_q.size() >= 4) chk("err_rd_data", log_q[3].data, 32'd0);
        repeat (20) @(negedge clk);
        chk("err_quiet_count", log_q.size(), 32'd4);
        chk("err_quiet_cmd", {30'd0, bus.avm_m0_write, bus.avm_m0_read}, 32'd0);
        force_en0 = 1'b0;
        log_q.delete();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        stop = 1'b1;
        chk("recover_error", {31'd0, error}, 32'd0);
        chk("recover_busy", {31'd0, busy}, 32'd1);
        @(negedge clk);
        stop = 1'b0;
        wait_idle(100, "recover_idle");
        chk("recover_count", log_q.size(), 32'd5);
        if (log_q.size() >= 5) begin
            for (int i = 0; i < 4; i++) begin
                chk($sformatf("recover%0d_addr", i), {30'd0, log_q[i].addr}, {30'd0, vecs[i].addr});
                chk($sformatf("recover%0d_data", i), log_q[i].data, vecs[i].data);
            end
            chk("recover_dis", {29'd0, log_q[4].wr, log_q[4].addr}, 32'h6);
            chk("recover_dis_gap", log_q[4].cyc - log_q[3].cyc, 32'd5);
        end

        // waitrequest stuck high -> timeout after 8 stalled cycles
        stuck = 1'b1;
        log_q.delete();
        pulse_start(s);
        chk("to_first_cmd", {bus.avm_m0_write, bus.avm_m0_address, bus.avm_m0_writedata[28:0]},
            {1'b1, 2'd1, 29'd100});
        repeat (7) @(negedge clk);
        chk("to_err_before", {31'd0, error}, 32'd0);
        chk("to_held", {31'd0, bus.avm_m0_write}, 32'd1);
        @(negedge clk);
        chk("to_err_after", {31'd0, error}, 32'd1);
        chk("to_dropped", {28'd0, bus.avm_m0_byteenable}, 32'd0);
        chk("to_busy", {31'd0, busy}, 32'd0);
        chk("to_width", width, 32'd30);
        chk("to_count", log_q.size(), 32'd0);
        stuck = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/pwm_avalon_ramp_master.md
# pwm_avalon_ramp_master

Avalon-MM master that programs the PWM agent's three-register map (0 = pulse_width, 1 = period, 2 = enable) without a CPU, then ramps pulse_width up and down ("breathing" output). It sits in the Qsys system as a master connected to one PWM agent's s0 slave port. It is driven by conduit start/stop controls and reports busy/error status.

## Interface
- PERIOD, 500000, value written to period register; ramp ceiling
- STEP, 5000, pulse_width increment/decrement per update, nonzero
- STEP_CYCLES, 50000, clock cycles spent in WAIT between updates, ≥1
- TIMEOUT, 1024, max cycles any transaction may be held by waitrequest
- csi_clk  in  1  sole clock, rising edge
- rsi_rst_n  in  1  reset, synchronous, active-low
- avm_m0_address  out  2  word address into PWM register map
- avm_m0_read  out  1  read command
- avm_m0_write  out  1  write command
- avm_m0_writedata  out  32  write data
- avm_m0_byteenable  out  4  always 4'b1111 while a command is asserted, else 0
- avm_m0_readdata  in  32  read data, valid on completing cycle
- avm_m0_waitrequest  in  1  agent stall
- coe_start  in  1  level; begin sequence
- coe_stop  in  1  level; request disable
- coe_busy  out  1  high in any state except IDLE and ERROR
- coe_error  out  1  sticky error flag
- coe_width  out  32  last pulse_width value successfully written

## Operation
- States: IDLE, WR_PERIOD, WR_WIDTH0, WR_ENABLE, RD_ENABLE, WAIT, WR_WIDTH, WR_DISABLE, ERROR.
- IDLE: coe_start=1 → WR_PERIOD; width reg ← 0, direction ← up, stop latch cleared.
- WR_PERIOD writes PERIOD to addr 1; WR_WIDTH0 writes 0 to addr 0; WR_ENABLE writes 1 to addr 2; RD_ENABLE reads addr 2.
- RD_ENABLE completion: readdata[0]==1 → WAIT (counter loaded STEP_CYCLES); else → ERROR.
- WAIT: counter decrements each cycle; at 1, → WR_DISABLE if stop latch set, else compute next width → WR_WIDTH.
- Next width (32-bit unsigned, no wrap): up: if width+STEP ≥ PERIOD (compare in 33 bits) → PERIOD, direction ← down; else width+STEP. Down: if width ≤ STEP → 0, direction ← up; else width−STEP.
- WR_WIDTH writes next width to addr 0; on completion coe_width ← that value, → WAIT (counter reloaded).
- WR_DISABLE writes 0 to addr 2; on completion → IDLE.
- coe_stop sampled every cycle while busy into stop latch; honored only at WAIT exit, so in-flight transactions always finish. Stop during setup states proceeds through RD_ENABLE, then one WAIT, then WR_DISABLE.
- coe_start ignored while busy. In ERROR, coe_start=1 clears coe_error and → WR_PERIOD (same init as IDLE).
- Timeout: per-transaction counter; if waitrequest stays high TIMEOUT consecutive cycles → ERROR, command dropped.
- ERROR: all commands deasserted, coe_error=1, stays until coe_start or reset.

## Timing
- Reset (rsi_rst_n low at rising edge): state IDLE; all avm_m0_* outputs 0; coe_busy=0, coe_error=0, coe_width=0; counters, latch, direction cleared. Reset mid-transaction aborts it immediately.
- Command state asserts read/write, address, writedata, byteenable registered on state entry; held constant while waitrequest=1.
- Transaction completes at the rising edge where command and waitrequest=0; next state entered that edge; read data captured that edge.
- Back-to-back transactions allowed: command may remain asserted across consecutive completions with new address/data.
- waitrequest tied 0: coe_start high at edge N → WR_PERIOD write visible cycle N+1, WR_WIDTH0 N+2, WR_ENABLE N+3, RD_ENABLE N+4, WAIT from N+5; first WR_WIDTH at N+5+STEP_CYCLES.
- Update period in steady state = STEP_CYCLES + 1 + waitrequest stall cycles.

## Test plan
- Waitrequest 0, model agent, PERIOD=100, STEP=30, STEP_CYCLES=4: start → writes (1,100),(0,0),(2,1), read 2 returns 1; widths 30,60,90,100,70,40,10,0,30 each 5 cycles apart.
- Agent holds waitrequest 3 cycles per access: address/data stable during stall, each transaction completes exactly once, no duplicate writes.
- Read of enable returns 0 → coe_error=1, coe_busy=0, no further commands; coe_start → error clears, full init sequence reissued.
- waitrequest stuck high, TIMEOUT=8: write dropped after 8 cycles, ERROR entered; coe_width unchanged.
- coe_stop pulsed during a stalled WR_WIDTH: write completes, next WAIT runs STEP_CYCLES, then write (2,0), IDLE, busy=0.
- Reset asserted mid-ramp during a write: next cycle all outputs 0, state IDLE; start restarts from width 0.
